// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interruptor: register map, decoder
// result type and the write payload carried from decode to the register file.
package clint_pkg;

  localparam int unsigned MtimeW = 64;
  localparam int unsigned MtimeBytes = MtimeW / 8;

  localparam logic [15:0] ClintMsip     = 16'h0000;
  localparam logic [15:0] ClintMtimecmp = 16'h4000;
  localparam logic [15:0] ClintMtime    = 16'hBFF8;

  typedef enum logic [1:0] {
    RegMsip,
    RegMtimecmp,
    RegMtime,
    RegNone
  } clint_reg_t;

  // Bus write aligned onto the 64-bit register view.
  typedef struct packed {
    clint_reg_t              target;
    logic                    hi_half;
    logic [MtimeW-1:0]       data;
    logic [MtimeBytes-1:0]   be;
  } clint_wr_t;

  // Replace only the enabled byte lanes of old_v with new_v.
  function automatic logic [MtimeW-1:0] lane_merge(input logic [MtimeW-1:0]     old_v,
                                                   input logic [MtimeW-1:0]     new_v,
                                                   input logic [MtimeBytes-1:0] be);
    logic [MtimeW-1:0] res;
    res = old_v;
    for (int i = 0; i < int'(MtimeBytes); i++) begin
      if (be[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/clint_if.sv
// Wishbone slave port of the CLINT, grouped so the core bus can be passed as one.
interface clint_if #(
  parameter int unsigned ADDR_SIZE = 16,
  parameter int unsigned DATA_SIZE = 64
);

  logic                   wb_cyc_i;
  logic                   wb_stb_i;
  logic                   wb_we_i;
  logic [ADDR_SIZE-1:0]   wb_adr_i;
  logic [DATA_SIZE/8-1:0] wb_sel_i;
  logic [DATA_SIZE-1:0]   wb_dat_i;
  logic [DATA_SIZE-1:0]   wb_dat_o;
  logic                   wb_ack_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_sel_i, wb_dat_i,
    output wb_dat_o, wb_ack_o
  );

endinterface

// File: rtl/clint_prescaler.sv
// Divides the system clock down to the mtime tick rate.
module clint_prescaler #(
  parameter int unsigned CLOCK_CYCLES_PER_TICK = 100
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CntW = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLOCK_CYCLES_PER_TICK - 1);

  logic [CntW-1:0] count_q, count_d;
  logic            tick_q;

  always_comb begin
    count_d = count_q + CntW'(1);
    if (count_q == CntLast) count_d = '0;
  end

  // tick_q mirrors (count_q == CntLast) one register earlier, so it is never combinational.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      tick_q  <= 1'(CLOCK_CYCLES_PER_TICK == 1);
    end else begin
      count_q <= count_d;
      tick_q  <= (count_d == CntLast);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/clint.sv
// Core-local interruptor: Wishbone-mapped msip, mtimecmp and free-running mtime.
module clint
  import clint_pkg::*;
#(
  parameter int unsigned DATA_SIZE             = 64,
  parameter int unsigned CLOCK_CYCLES_PER_TICK = 100,
  parameter int unsigned ADDR_SIZE             = 16
) (
  input  logic          clock,
  input  logic          reset,
  clint_if.slave        bus,
  output logic          msip,
  output logic [63:0]   mtime,
  output logic [63:0]   mtimecmp
);

  logic                 tick;
  logic                 ack_q;
  logic [DATA_SIZE-1:0] dat_q;
  logic                 msip_q, msip_d;
  logic [63:0]          mtimecmp_q, mtimecmp_d;
  logic [63:0]          mtime_q, mtime_d;

  logic                 req_c;
  logic                 hi_half_c;
  logic [ADDR_SIZE-1:0] base_adr_c;
  clint_reg_t           reg_c;
  clint_wr_t            wr_c;
  logic [63:0]          rd_word_c;
  logic [DATA_SIZE-1:0] rd_data_c;
  logic                 unused_adr;

  clint_prescaler #(
    .CLOCK_CYCLES_PER_TICK(CLOCK_CYCLES_PER_TICK)
  ) u_prescaler (
    .clock(clock),
    .reset(reset),
    .tick (tick)
  );

  // Byte offsets below the word size never select anything.
  assign unused_adr = &{1'b0, bus.wb_adr_i[1:0]};

  // Decode: every register sits on an 8-byte boundary; bit 2 picks the half on a 32-bit bus.
  always_comb begin
    req_c      = bus.wb_cyc_i & bus.wb_stb_i & ~ack_q;
    hi_half_c  = (DATA_SIZE == 32) ? bus.wb_adr_i[2] : 1'b0;
    base_adr_c = {bus.wb_adr_i[ADDR_SIZE-1:3], 3'b000};

    reg_c = RegNone;
    if (base_adr_c == ADDR_SIZE'(ClintMsip) && !hi_half_c) reg_c = RegMsip;
    else if (base_adr_c == ADDR_SIZE'(ClintMtimecmp))      reg_c = RegMtimecmp;
    else if (base_adr_c == ADDR_SIZE'(ClintMtime))         reg_c = RegMtime;

    wr_c.target  = (req_c & bus.wb_we_i) ? reg_c : RegNone;
    wr_c.hi_half = hi_half_c;
    wr_c.data    = 64'(bus.wb_dat_i) << (hi_half_c ? 6'd32 : 6'd0);
    wr_c.be      = 8'(bus.wb_sel_i) << (hi_half_c ? 3'd4 : 3'd0);

    case (reg_c)
      RegMsip:     rd_word_c = {63'd0, msip_q};
      RegMtimecmp: rd_word_c = mtimecmp_q;
      RegMtime:    rd_word_c = mtime_q;
      default:     rd_word_c = '0;
    endcase
    rd_data_c = DATA_SIZE'(rd_word_c >> (hi_half_c ? 6'd32 : 6'd0));
  end

  always_comb begin
    msip_d = msip_q;
    if (wr_c.target == RegMsip && wr_c.be[0]) msip_d = wr_c.data[0];

    mtimecmp_d = mtimecmp_q;
    if (wr_c.target == RegMtimecmp) mtimecmp_d = lane_merge(mtimecmp_q, wr_c.data, wr_c.be);
  end

  // A write wins over the tick; a high-half-only write leaves the low half counting without carry.
  always_comb begin
    mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
    if (wr_c.target == RegMtime) begin
      mtime_d = lane_merge(mtime_q, wr_c.data, wr_c.be);
      if (wr_c.hi_half && tick) mtime_d[31:0] = mtime_q[31:0] + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
    end else begin
      ack_q      <= req_c;
      if (req_c) dat_q <= rd_data_c;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
    end
  end

  assign bus.wb_ack_o = ack_q;
  assign bus.wb_dat_o = dat_q;
  assign msip         = msip_q;
  assign mtime        = mtime_q;
  assign mtimecmp     = mtimecmp_q;

endmodule

// File: tb/tb_clint.sv
// Self-checking bench for clint: 32-bit bus, 4-cycle tick, behavioural model plus directed literals.
`timescale 1ns/1ps
module tb_clint;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned N  = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        msip;
  logic [63:0] mtime, mtimecmp;

  int n_checks = 0;
  int n_fail   = 0;

  clint_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();

  clint #(
    .DATA_SIZE(DW),
    .CLOCK_CYCLES_PER_TICK(N),
    .ADDR_SIZE(AW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .bus     (bus),
    .msip    (msip),
    .mtime   (mtime),
    .mtimecmp(mtimecmp)
  );

  always #5 clock = ~clock;

  initial begin
    #500us;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] put_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = new_v[8*i +: 8];
    return r;
  endfunction

  // Reference model: counts edges since reset, ticks every N-th edge, applies the register map.
  int unsigned m_edges;
  logic        m_msip, m_ack;
  logic [63:0] m_time, m_cmp;
  logic [31:0] m_dat;

  always @(posedge clock or posedge reset) begin : model
    logic        tick, req;
    logic [15:0] a;
    logic [63:0] nt;
    if (reset) begin
      m_edges <= 0;
      m_msip  <= 1'b0;
      m_ack   <= 1'b0;
      m_time  <= 64'd0;
      m_cmp   <= '1;
      m_dat   <= 32'd0;
    end else begin
      tick = (m_edges % N) == N - 1;
      req  = bus.wb_cyc_i && bus.wb_stb_i && !m_ack;
      nt   = m_time + (tick ? 64'd1 : 64'd0);
      if (req) begin
        a = {bus.wb_adr_i[15:2], 2'b00};
        case (a)
          16'h0000: m_dat <= {31'd0, m_msip};
          16'h4000: m_dat <= m_cmp[31:0];
          16'h4004: m_dat <= m_cmp[63:32];
          16'hBFF8: m_dat <= m_time[31:0];
          16'hBFFC: m_dat <= m_time[63:32];
          default:  m_dat <= 32'd0;
        endcase
        if (bus.wb_we_i) begin
          case (a)
            16'h0000: if (bus.wb_sel_i[0]) m_msip <= bus.wb_dat_i[0];
            16'h4000: m_cmp[31:0]  <= put_bytes(m_cmp[31:0], bus.wb_dat_i, bus.wb_sel_i);
            16'h4004: m_cmp[63:32] <= put_bytes(m_cmp[63:32], bus.wb_dat_i, bus.wb_sel_i);
            16'hBFF8: nt = {m_time[63:32], put_bytes(m_time[31:0], bus.wb_dat_i, bus.wb_sel_i)};
            16'hBFFC: nt = {put_bytes(m_time[63:32], bus.wb_dat_i, bus.wb_sel_i),
                            m_time[31:0] + (tick ? 32'd1 : 32'd0)};
            default: ;
          endcase
        end
      end
      m_edges <= m_edges + 1;
      m_ack   <= req;
      m_time  <= nt;
    end
  end

  // Cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    if (!reset) begin
      check("ack", {63'd0, bus.wb_ack_o}, {63'd0, m_ack});
      check("msip", {63'd0, msip}, {63'd0, m_msip});
      check("mtime", mtime, m_time);
      check("mtimecmp", mtimecmp, m_cmp);
      if (m_ack) check("rdata", {32'd0, bus.wb_dat_o}, {32'd0, m_dat});
    end
  end

  task automatic bus_idle();
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_we_i  = 1'b0;
    bus.wb_adr_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_dat_i = '0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    bus_idle();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic xfer(input logic we, input logic [15:0] adr, input logic [3:0] sel,
                      input logic [31:0] wd, output logic [31:0] rd);
    int k;
    @(negedge clock);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_we_i  = we;
    bus.wb_adr_i = adr;
    bus.wb_sel_i = sel;
    bus.wb_dat_i = wd;
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!bus.wb_ack_o && k < 20);
    if (!bus.wb_ack_o) check("ack_timeout", 64'd0, 64'd1);
    rd = bus.wb_dat_o;
    bus_idle();
  endtask

  logic [31:0] rd;
  logic [15:0] adr_tab [8] = '{16'h0000, 16'h0004, 16'h4000, 16'h4004,
                               16'hBFF8, 16'hBFFC, 16'h1234, 16'hBFF8};

  initial begin
    int k;
    logic [15:0] a;
    reset = 1'b1;
    bus_idle();
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset values through the bus.
    xfer(1'b0, 16'hBFF8, 4'hF, 32'd0, rd);  check("t1_mtime_lo", {32'd0, rd}, 64'd0);
    xfer(1'b0, 16'hBFFC, 4'hF, 32'd0, rd);  check("t1_mtime_hi", {32'd0, rd}, 64'd0);
    xfer(1'b0, 16'h4000, 4'hF, 32'd0, rd);  check("t1_cmp_lo", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
    xfer(1'b0, 16'h4004, 4'hF, 32'd0, rd);  check("t1_cmp_hi", {32'd0, rd}, 64'h0000_0000_FFFF_FFFF);
    check("t1_msip", {63'd0, msip}, 64'd0);

    // Tick spacing of N cycles.
    do_reset();
    repeat (36) @(posedge clock); #1;
    check("t2_mtime_36", mtime, 64'd9);
    repeat (3) @(posedge clock); #1;
    check("t2_mtime_39", mtime, 64'd9);
    @(posedge clock); #1;
    check("t2_mtime_40", mtime, 64'd10);

    // msip set/clear.
    xfer(1'b1, 16'h0000, 4'hF, 32'hFFFF_FFFF, rd);
    check("t3_msip_set", {63'd0, msip}, 64'd1);
    xfer(1'b0, 16'h0000, 4'hF, 32'd0, rd);
    check("t3_msip_read", {32'd0, rd}, 64'd1);
    xfer(1'b1, 16'h0000, 4'hF, 32'd0, rd);
    check("t3_msip_clr", {63'd0, msip}, 64'd0);

    // Timer compare.
    do_reset();
    xfer(1'b1, 16'h4004, 4'hF, 32'd0, rd);
    xfer(1'b1, 16'h4000, 4'hF, 32'd5, rd);
    k = 0;
    while (mtime < mtimecmp && k < 100) begin @(negedge clock); k++; end
    check("t4_mtip_high", {63'd0, mtime >= mtimecmp}, 64'd1);
    check("t4_mtime_at_mtip", mtime, 64'd5);
    xfer(1'b1, 16'h4000, 4'hF, 32'hFFFF_FFFF, rd);
    xfer(1'b1, 16'h4004, 4'hF, 32'hFFFF_FFFF, rd);
    check("t4_mtip_low", {63'd0, mtime >= mtimecmp}, 64'd0);

    // mtime write colliding with a tick, then wrap.
    xfer(1'b1, 16'hBFFC, 4'hF, 32'hFFFF_FFFF, rd);
    while ((m_edges % N) != N - 2) @(negedge clock);
    xfer(1'b1, 16'hBFF8, 4'hF, 32'hFFFF_FFFF, rd);
    check("t5_mtime_kept", mtime, 64'hFFFF_FFFF_FFFF_FFFF);
    k = 0;
    while (mtime != 64'd0 && k < 2 * N) begin @(negedge clock); k++; end
    check("t5_mtime_wrap", mtime, 64'd0);
    xfer(1'b1, 16'hBFF8, 4'h1, 32'h0000_00AA, rd);
    check("t5_byte0_only", mtime, 64'h0000_0000_0000_00AA);

    // Held request completes every second cycle.
    @(negedge clock);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 16'h4000;
    bus.wb_sel_i = 4'hF;
    #1 check("t6_ack_0", {63'd0, bus.wb_ack_o}, 64'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("t6_ack_pattern", {63'd0, bus.wb_ack_o}, (i % 2 == 0) ? 64'd1 : 64'd0);
    end
    bus_idle();
    xfer(1'b0, 16'h1234, 4'hF, 32'd0, rd);
    check("t6_unmapped", {32'd0, rd}, 64'd0);

    // Reset during an ack drops it immediately.
    @(negedge clock);
    bus.wb_cyc_i = 1'b1;
    bus.wb_stb_i = 1'b1;
    bus.wb_adr_i = 16'h0000;
    @(posedge clock); #1;
    check("t6_ack_before_rst", {63'd0, bus.wb_ack_o}, 64'd1);
    reset = 1'b1;
    #1 check("t6_ack_in_rst", {63'd0, bus.wb_ack_o}, 64'd0);
    bus_idle();
    @(negedge clock);
    reset = 1'b0;

    // Randomised traffic, including changes mid-request and ignored address LSBs.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      k = $urandom_range(0, 8);
      a = (k == 8) ? 16'($urandom) : adr_tab[k];
      bus.wb_cyc_i = ($urandom_range(0, 3) != 0);
      bus.wb_stb_i = ($urandom_range(0, 4) != 0);
      bus.wb_we_i  = ($urandom_range(0, 2) == 0);
      bus.wb_adr_i = a | 16'($urandom_range(0, 3));
      bus.wb_sel_i = 4'($urandom);
      bus.wb_dat_i = $urandom;
    end
    bus_idle();
    repeat (4) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
